// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C master arbiter and its round-robin picker.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_REQ = 2;
  localparam int BYTE_W      = 8;

endpackage

// File: rtl/i2c_arbiter_if.sv
// Requester-side and master-side signals of the I2C arbiter; the arbiter uses the slave modport.
interface i2c_arbiter_if #(
  parameter int NUM_REQ = 2
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_enable;
  logic [NUM_REQ-1:0]   req_rw;
  logic [8*NUM_REQ-1:0] req_data_wr;
  logic [NUM_REQ-1:0]   gnt;
  logic [IW-1:0]        gnt_id;
  logic [NUM_REQ-1:0]   req_busy;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           req_data_rd;
  logic                 m_enable;
  logic                 m_rw;
  logic [7:0]           m_data_wr;
  logic                 m_busy;
  logic                 m_ready;
  logic [7:0]           m_data_rd;
  logic                 timeout_err;

  modport slave (
    input  req, req_enable, req_rw, req_data_wr, m_busy, m_ready, m_data_rd,
    output gnt, gnt_id, req_busy, req_ready, req_data_rd,
           m_enable, m_rw, m_data_wr, timeout_err
  );

  modport master (
    output req, req_enable, req_rw, req_data_wr, m_busy, m_ready, m_data_rd,
    input  gnt, gnt_id, req_busy, req_ready, req_data_rd,
           m_enable, m_rw, m_data_wr, timeout_err
  );

endinterface

// File: rtl/i2c_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req_i searching upward from last_i+1 with wrap.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Scan farthest-to-nearest so the nearest hit is the one that sticks.
  always_comb begin
    int j;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(last_i) + k) % N;
      if (req_i[IW'(j)]) begin
        idx_o   = IW'(j);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master among NUM_REQ requesters; grant held per transaction.
// Optional grant timeout enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int HOLD_MAX = 65535
) (
  input logic          clk,
  input logic          rst,
  i2c_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("i2c_arbiter: NUM_REQ must be 2..8");
  end
  if (HOLD_MAX < 1) begin : g_bad_hold_max
    $error("i2c_arbiter: HOLD_MAX must be >= 1");
  end

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      gnt_id_q, gnt_id_d;
  logic [NUM_REQ-1:0] elig;
  logic [IW-1:0]      pick_idx;
  logic               pick_vld;
  logic               in_grant;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               tmo_q, tmo_d;
  logic [NUM_REQ-1:0] blk_q, blk_d;

  // A revoked requester stays blocked until it lowers req once.
  assign elig            = bus.req & ~blk_q;
  assign bus.timeout_err = tmo_q;
`else
  assign elig            = bus.req;
  assign bus.timeout_err = 1'b0;
`endif

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req_i   (elig),
    .last_i  (gnt_id_q),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= IW'(NUM_REQ - 1);
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
      blk_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      blk_q    <= blk_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    tmo_d    = 1'b0;
    blk_d    = blk_q & bus.req;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          gnt_id_d        = pick_idx;
          state_d         = GRANT;
`ifdef I2C_ARB_TIMEOUT_EN
          cnt_d           = '0;
`endif
        end
      end
      GRANT: begin
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (!bus.req[gnt_id_q]) begin
          gnt_d   = '0;
          state_d = DRAIN;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (cnt_d == CW'(HOLD_MAX)) begin
          gnt_d           = '0;
          state_d         = DRAIN;
          tmo_d           = 1'b1;
          blk_d[gnt_id_q] = 1'b1;
        end
`endif
      end
      DRAIN: begin
        // Wait for the master to finish whatever the previous owner started.
        if (bus.m_ready && !bus.m_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign in_grant = (state_q == GRANT);

  always_comb begin
    bus.m_enable  = 1'b0;
    bus.m_rw      = 1'b0;
    bus.m_data_wr = 8'h00;
    bus.req_busy  = '1;
    bus.req_ready = '0;
    if (in_grant) begin
      bus.m_enable            = bus.req_enable[gnt_id_q];
      bus.m_rw                = bus.req_rw[gnt_id_q];
      bus.m_data_wr           = bus.req_data_wr[{gnt_id_q, 3'b000} +: BYTE_W];
      bus.req_busy[gnt_id_q]  = bus.m_busy;
      bus.req_ready[gnt_id_q] = bus.m_ready;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.gnt_id      = gnt_id_q;
  assign bus.req_data_rd = bus.m_data_rd;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter (NUM_REQ=2): vector table, corner-case sequences, random run vs reference model.
module tb_i2c_arbiter;

  localparam int N    = 2;
  localparam int HOLD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_arbiter_if #(.NUM_REQ(N)) bus ();

  i2c_arbiter #(.NUM_REQ(N), .HOLD_MAX(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [1:0]  req_r = '0, en_r = '0, rw_r = '0;
  logic [15:0] dwr_r = '0;
  logic        busy_r = 1'b0, rdy_r = 1'b1;
  logic [7:0]  drd_r = '0;

  assign bus.req         = req_r;
  assign bus.req_enable  = en_r;
  assign bus.req_rw      = rw_r;
  assign bus.req_data_wr = dwr_r;
  assign bus.m_busy      = busy_r;
  assign bus.m_ready     = rdy_r;
  assign bus.m_data_rd   = drd_r;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0] gnt;
    logic       id;
    logic       men;
    logic       mrw;
    logic [7:0] mdwr;
    logic [1:0] busy;
    logic [1:0] rdy;
    logic [7:0] drd;
    logic       tmo;
  } out_t;

  task automatic cmp_out(input string tag, input out_t e);
    chk({tag, "_gnt"},     bus.gnt,         e.gnt);
    chk({tag, "_gnt_id"},  bus.gnt_id,      e.id);
    chk({tag, "_m_en"},    bus.m_enable,    e.men);
    chk({tag, "_m_rw"},    bus.m_rw,        e.mrw);
    chk({tag, "_m_dwr"},   bus.m_data_wr,   e.mdwr);
    chk({tag, "_busy"},    bus.req_busy,    e.busy);
    chk({tag, "_ready"},   bus.req_ready,   e.rdy);
    chk({tag, "_data_rd"}, bus.req_data_rd, e.drd);
    chk({tag, "_tmo"},     bus.timeout_err, e.tmo);
  endtask

  // ---------------- reference model (owner index, -1 = nobody) ----------------
  int         m_owner, m_last, m_hold;
  bit         m_drain, m_tmo;
  logic [1:0] m_blk;

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_hold = 0;
    m_drain = 0; m_tmo = 0; m_blk = '0;
  endtask

  function automatic out_t model_out();
    out_t e;
    e.gnt = '0; e.id = 1'(m_last); e.men = 0; e.mrw = 0; e.mdwr = 8'h00;
    e.busy = 2'b11; e.rdy = 2'b00; e.drd = drd_r; e.tmo = m_tmo;
    if (m_owner >= 0) begin
      e.gnt[m_owner]  = 1'b1;
      e.men           = en_r[m_owner];
      e.mrw           = rw_r[m_owner];
      e.mdwr          = dwr_r[m_owner*8 +: 8];
      e.busy[m_owner] = busy_r;
      e.rdy[m_owner]  = rdy_r;
    end
    return e;
  endfunction

  task automatic model_step();
    logic [1:0] blk_n;
    bit         tmo_n;
    if (rst) begin
      model_reset();
      return;
    end
    blk_n = m_blk & req_r;
    tmo_n = 0;
    if (m_owner >= 0) begin
      m_hold++;
      if (!req_r[m_owner]) begin
        m_owner = -1; m_drain = 1;
      end
`ifdef I2C_ARB_TIMEOUT_EN
      else if (m_hold == HOLD) begin
        blk_n[m_owner] = 1'b1; tmo_n = 1;
        m_owner = -1; m_drain = 1;
      end
`endif
    end else if (m_drain) begin
      if (rdy_r && !busy_r) m_drain = 0;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (req_r[i] && !m_blk[i]) begin
          m_owner = i; m_last = i; m_hold = 0;
          break;
        end
      end
    end
    m_blk = blk_n;
    m_tmo = tmo_n;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic [1:0] req, en;
    logic       busy, rdy;
    logic [1:0] e_gnt;
    logic       e_id, e_men, e_rw;
    logic [7:0] e_dwr;
    logic [1:0] e_busy, e_rdy;
  } vec_t;

  function automatic vec_t mk(logic r, logic [1:0] rq, logic [1:0] en, logic b, logic rd,
                              logic [1:0] g, logic id, logic men, logic rw, logic [7:0] dw,
                              logic [1:0] eb, logic [1:0] er);
    vec_t v;
    v.rst = r; v.req = rq; v.en = en; v.busy = b; v.rdy = rd;
    v.e_gnt = g; v.e_id = id; v.e_men = men; v.e_rw = rw; v.e_dwr = dw;
    v.e_busy = eb; v.e_rdy = er;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_rst();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Returns at a negedge with the first nonzero grant seen, or ok=0 after maxc cycles.
  task automatic wait_any(input int maxc, output logic [1:0] g, output bit ok);
    ok = 0;
    g  = '0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (bus.gnt != 2'b00) begin
        g = bus.gnt; ok = 1;
        return;
      end
      tick();
    end
  endtask

  vec_t tbl[16];
  out_t e;

  initial begin
    logic [1:0] g;
    bit         ok;
    int         n;
    int         o;

    tbl[0]  = mk(0, 2'b00, 2'b11, 0, 1, 2'b00, 1, 0, 0, 8'h00, 2'b11, 2'b00);
    tbl[1]  = mk(0, 2'b01, 2'b11, 0, 1, 2'b00, 1, 0, 0, 8'h00, 2'b11, 2'b00);
    tbl[2]  = mk(0, 2'b01, 2'b11, 0, 1, 2'b01, 0, 1, 0, 8'h02, 2'b10, 2'b01);
    tbl[3]  = mk(0, 2'b11, 2'b11, 1, 0, 2'b01, 0, 1, 0, 8'h02, 2'b11, 2'b00);
    tbl[4]  = mk(0, 2'b10, 2'b11, 1, 0, 2'b01, 0, 1, 0, 8'h02, 2'b11, 2'b00);
    tbl[5]  = mk(0, 2'b10, 2'b11, 1, 0, 2'b00, 0, 0, 0, 8'h00, 2'b11, 2'b00);
    tbl[6]  = mk(0, 2'b10, 2'b11, 0, 1, 2'b00, 0, 0, 0, 8'h00, 2'b11, 2'b00);
    tbl[7]  = mk(0, 2'b10, 2'b11, 0, 1, 2'b00, 0, 0, 0, 8'h00, 2'b11, 2'b00);
    tbl[8]  = mk(0, 2'b11, 2'b01, 0, 1, 2'b10, 1, 0, 1, 8'h13, 2'b01, 2'b10);
    tbl[9]  = mk(0, 2'b01, 2'b11, 0, 1, 2'b10, 1, 1, 1, 8'h13, 2'b01, 2'b10);
    tbl[10] = mk(0, 2'b01, 2'b11, 0, 1, 2'b00, 1, 0, 0, 8'h00, 2'b11, 2'b00);
    tbl[11] = mk(0, 2'b01, 2'b11, 0, 1, 2'b00, 1, 0, 0, 8'h00, 2'b11, 2'b00);
    tbl[12] = mk(0, 2'b01, 2'b11, 0, 1, 2'b01, 0, 1, 0, 8'h02, 2'b10, 2'b01);
    tbl[13] = mk(1, 2'b01, 2'b11, 0, 1, 2'b01, 0, 1, 0, 8'h02, 2'b10, 2'b01);
    tbl[14] = mk(0, 2'b11, 2'b11, 0, 1, 2'b00, 1, 0, 0, 8'h00, 2'b11, 2'b00);
    tbl[15] = mk(0, 2'b11, 2'b11, 0, 1, 2'b01, 0, 1, 0, 8'h02, 2'b10, 2'b01);

    // ---------------- table-driven vectors ----------------
    dwr_r = 16'h1302;
    rw_r  = 2'b10;
    apply_rst();
    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst; req_r = tbl[i].req; en_r = tbl[i].en;
      busy_r = tbl[i].busy; rdy_r = tbl[i].rdy; drd_r = 8'hA0 + 8'(i);
      @(negedge clk);
      e.gnt = tbl[i].e_gnt; e.id = tbl[i].e_id; e.men = tbl[i].e_men; e.mrw = tbl[i].e_rw;
      e.mdwr = tbl[i].e_dwr; e.busy = tbl[i].e_busy; e.rdy = tbl[i].e_rdy;
      e.drd = 8'hA0 + 8'(i); e.tmo = 1'b0;
      cmp_out($sformatf("vec%0d", i), e);
      tick();
    end
    rst = 1'b0;

    // ---------------- drain wait: owner leaves while master still busy ----------------
    apply_rst();
    req_r = 2'b01; en_r = 2'b11; busy_r = 0; rdy_r = 1;
    wait_any(5, g, ok);
    chk("drain_first_gnt", {30'd0, g}, 2'b01);
    tick();
    req_r = 2'b10; busy_r = 1; rdy_r = 0;
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("drain_gnt%0d", i), bus.gnt, 2'b00);
      chk($sformatf("drain_men%0d", i), bus.m_enable, 1'b0);
      tick();
    end
    busy_r = 0; rdy_r = 1;
    @(negedge clk); chk("drain_exit_gnt", bus.gnt, 2'b00); tick();
    @(negedge clk); chk("drain_idle_gnt", bus.gnt, 2'b00); tick();
    @(negedge clk); chk("drain_next_gnt", bus.gnt, 2'b10); tick();

    // ---------------- fairness: both hold req across 4 transactions ----------------
    apply_rst();
    req_r = 2'b11; busy_r = 0; rdy_r = 1;
    for (int t = 0; t < 4; t++) begin
      wait_any(8, g, ok);
      chk($sformatf("fair_found%0d", t), ok, 1);
      chk($sformatf("fair_owner%0d", t), {30'd0, g}, (t % 2 == 0) ? 2'b01 : 2'b10);
      o = g[1] ? 1 : 0;
      tick();
      tick();
      req_r[o] = 1'b0;
      tick();
      req_r = 2'b11;
    end

`ifdef I2C_ARB_TIMEOUT_EN
    // ---------------- grant timeout ----------------
    apply_rst();
    req_r = 2'b11; busy_r = 0; rdy_r = 1;
    wait_any(5, g, ok);
    chk("tmo_first_gnt", {30'd0, g}, 2'b01);
    n = 0;
    while (bus.gnt == 2'b01 && n < 40) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk("tmo_hold_cycles", n, HOLD);
    chk("tmo_pulse", bus.timeout_err, 1'b1);
    tick();
    @(negedge clk);
    chk("tmo_pulse_end", bus.timeout_err, 1'b0);
    tick();
    wait_any(6, g, ok);
    chk("tmo_other_gnt", {30'd0, g}, 2'b10);
    tick();
`endif

    // ---------------- randomized run against reference model ----------------
    rst = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst = (i < 2) || ($urandom_range(299) == 0);
      for (int b = 0; b < N; b++) begin
        if (req_r[b]) begin
          if ($urandom_range(9) == 0) req_r[b] = 1'b0;
        end else if ($urandom_range(5) == 0) begin
          req_r[b] = 1'b1;
        end
      end
      en_r   = 2'($urandom);
      rw_r   = 2'($urandom);
      dwr_r  = 16'($urandom);
      busy_r = 1'($urandom);
      rdy_r  = 1'($urandom);
      drd_r  = 8'($urandom);
      if (i >= 2) begin
        @(negedge clk);
        cmp_out("rnd", model_out());
      end
      @(posedge clk);
      model_step();
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
